// File: rtl/apb_ucpd_bmc_tx.sv
// BMC transmit serializer: preamble, LSB-first symbols, fixed tail.
// Paced by the clock generator's half-bit strobe.
module apb_ucpd_bmc_tx #(
  parameter int PREAMBLE_BITS = 64,
  parameter int SYM_W         = 5
) (
  input  logic             ic_clk,
  input  logic             ic_rst_n,
  input  logic             hbit_tick,
  input  logic             tx_start,
  input  logic             tx_abort,
  input  logic [SYM_W-1:0] sym_data,
  input  logic             sym_valid,
  input  logic             sym_last,
  output logic             sym_ready,
  output logic             cc_out,
  output logic             cc_oen,
  output logic             bmc_en,
  output logic             tx_done,
  output logic             underrun
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, TAIL} state_t;

  localparam logic [6:0] PRE_LAST = 7'(PREAMBLE_BITS - 1);
  localparam logic [2:0] SYM_LAST = 3'(SYM_W - 1);

  state_t           state, state_n;
  logic [6:0]       bit_cnt, bit_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic             phase, phase_n;
  logic             seg_done, seg_done_n;
  logic             tail_step, tail_step_n;
  logic [SYM_W-1:0] sh, sh_n;
  logic             sh_last, sh_last_n;
  logic [SYM_W-1:0] hold;
  logic             hold_last, hold_full;
  logic             abort_pending;
  logic             cc_out_n, cc_oen_n;
  logic             tx_done_n, underrun_n;
  logic             load, accept, flush;

  assign bmc_en    = (state != IDLE);
  assign sym_ready = ~hold_full & ((state == PRE) | (state == DATA))
                   & ~abort_pending;
  assign accept    = sym_valid & sym_ready;
  assign flush     = (state_n == TAIL);

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    bit_idx_n   = bit_idx;
    phase_n     = phase;
    seg_done_n  = seg_done;
    tail_step_n = tail_step;
    sh_n        = sh;
    sh_last_n   = sh_last;
    cc_out_n    = cc_out;
    cc_oen_n    = cc_oen;
    tx_done_n   = 1'b0;
    underrun_n  = 1'b0;
    load        = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_start) begin
          state_n    = PRE;
          bit_cnt_n  = '0;
          bit_idx_n  = '0;
          phase_n    = 1'b0;
          seg_done_n = 1'b0;
        end
      end
      PRE, DATA: begin
        if (hbit_tick) begin
          if (abort_pending) begin
            state_n     = TAIL;
            cc_out_n    = 1'b1;
            tail_step_n = 1'b0;
          end else if (!phase) begin
            cc_out_n = ~cc_out;
            cc_oen_n = 1'b1;
            phase_n  = 1'b1;
            if (seg_done) begin
              seg_done_n = 1'b0;
              if (state == DATA && sh_last) begin
                state_n     = TAIL;
                cc_out_n    = 1'b1;
                tail_step_n = 1'b0;
              end else if (hold_full) begin
                load      = 1'b1;
                sh_n      = hold;
                sh_last_n = hold_last;
                bit_idx_n = '0;
                state_n   = DATA;
              end else begin
                underrun_n  = 1'b1;
                state_n     = TAIL;
                cc_out_n    = 1'b1;
                tail_step_n = 1'b0;
              end
            end
          end else begin
            phase_n = 1'b0;
            if (state == PRE) begin
              cc_out_n = cc_out ^ bit_cnt[0];
              if (bit_cnt == PRE_LAST) seg_done_n = 1'b1;
              else bit_cnt_n = bit_cnt + 7'd1;
            end else begin
              cc_out_n = cc_out ^ sh[bit_idx];
              if (bit_idx == SYM_LAST) begin
                seg_done_n = 1'b1;
                bit_idx_n  = '0;
              end else begin
                bit_idx_n = bit_idx + 3'd1;
              end
            end
          end
        end
      end
      TAIL: begin
        if (hbit_tick) begin
          if (!tail_step) begin
            cc_out_n    = 1'b0;
            tail_step_n = 1'b1;
          end else begin
            cc_oen_n  = 1'b0;
            tx_done_n = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      phase     <= 1'b0;
      seg_done  <= 1'b0;
      tail_step <= 1'b0;
      sh        <= '0;
      sh_last   <= 1'b0;
      cc_out    <= 1'b0;
      cc_oen    <= 1'b0;
      tx_done   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      bit_idx   <= bit_idx_n;
      phase     <= phase_n;
      seg_done  <= seg_done_n;
      tail_step <= tail_step_n;
      sh        <= sh_n;
      sh_last   <= sh_last_n;
      cc_out    <= cc_out_n;
      cc_oen    <= cc_oen_n;
      tx_done   <= tx_done_n;
      underrun  <= underrun_n;
    end
  end

  // Single-entry holding register; any move into TAIL discards it.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      hold          <= '0;
      hold_last     <= 1'b0;
      hold_full     <= 1'b0;
      abort_pending <= 1'b0;
    end else begin
      if (flush) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold      <= sym_data;
        hold_last <= sym_last;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (state == IDLE) abort_pending <= 1'b0;
      else if (tx_abort) abort_pending <= 1'b1;
    end
  end

endmodule
